// File: rtl/jtag_tap_master.sv
`timescale 1ns/1ps
// jtag_tap_master
//   Fabric-side JTAG initiator. After reset it walks the TAP into
//   Test-Logic-Reset and then Run-Test/Idle. Each START request performs one
//   IR scan followed by an optional DR scan. Every transaction starts and
//   ends in Run-Test/Idle.
//
// Ports
//   CLK, RST_N   system clock, asynchronous active-low reset
//   START        single-cycle request, accepted only while BUSY=0
//   IR_IN        instruction, shifted LSB first
//   DR_IN        data, shifted LSB first
//   DR_LEN       number of DR bits (0 = IR scan only; clamped to DR_MAX)
//   TDO          serial data returned from the TAP
//   TCK/TMS/TDI  JTAG drive
//   BUSY         init sequence or transaction in progress
//   DONE         one-CLK pulse when a transaction completes
//   DR_OUT       captured TDO bits, LSB = first captured, unused bits 0
//
// Build option
//   JTAG_SKIP_IR_EN: skips the IR scan when IR_IN matches the last IR that
//   was fully shifted since reset.
module jtag_tap_master #(
  parameter int IR_WIDTH = 10,
  parameter int DR_MAX   = 32,
  parameter int HALF_DIV = 2
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         START,
  input  logic [IR_WIDTH-1:0]          IR_IN,
  input  logic [DR_MAX-1:0]            DR_IN,
  input  logic [$clog2(DR_MAX+1)-1:0]  DR_LEN,
  input  logic                         TDO,
  output logic                         TCK,
  output logic                         TMS,
  output logic                         TDI,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [DR_MAX-1:0]            DR_OUT
);

  localparam int LEN_W = $clog2(DR_MAX + 1);
  localparam int CMAX  = ((IR_WIDTH > DR_MAX) ? IR_WIDTH : DR_MAX) + 6;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int PH_W  = $clog2(2 * HALF_DIV);
  localparam int IRI_W = (IR_WIDTH > 1) ? $clog2(IR_WIDTH) : 1;
  localparam int DRI_W = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_IR_HDR, S_IR_SHIFT, S_IR_TAIL,
    S_DR_HDR, S_DR_SHIFT, S_DR_TAIL, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_MAX-1:0]   dr_q, dr_d, dout_q, dout_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CNT_W-1:0]    dr_last;
  logic                load;
`ifdef JTAG_SKIP_IR_EN
  logic [IR_WIDTH-1:0] last_ir_q, last_ir_d;
  logic                ir_valid_q, ir_valid_d;
`endif

  // TMS value for a given tick of a given state.
  function automatic logic tms_for(input state_e st, input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] last);
    case (st)
      S_INIT:     return cnt < CNT_W'(5);
      S_IR_HDR:   return cnt < CNT_W'(2);
      S_IR_SHIFT: return cnt == CNT_W'(IR_WIDTH - 1);
      S_IR_TAIL:  return cnt == '0;
      S_DR_HDR:   return cnt == '0;
      S_DR_SHIFT: return cnt == last;
      S_DR_TAIL:  return cnt == '0;
      default:    return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    ir_d    = ir_q;
    dr_d    = dr_q;
    len_d   = len_q;
    dout_d  = dout_q;
    load    = 1'b0;
`ifdef JTAG_SKIP_IR_EN
    last_ir_d  = last_ir_q;
    ir_valid_d = ir_valid_q;
`endif

    if (state_q == S_IDLE || state_q == S_FIN) begin
      if (state_q == S_FIN) state_d = S_IDLE;
      if (START) begin
        ir_d    = IR_IN;
        dr_d    = DR_IN;
        len_d   = (DR_LEN > LEN_W'(DR_MAX)) ? LEN_W'(DR_MAX) : DR_LEN;
        dout_d  = '0;
        cnt_d   = '0;
        phase_d = '0;
        load    = 1'b1;
        state_d = S_IR_HDR;
`ifdef JTAG_SKIP_IR_EN
        if (ir_valid_q && IR_IN == last_ir_q)
          state_d = (len_d == '0) ? S_FIN : S_DR_HDR;
`endif
      end
    end else begin
      // Rising TCK and TDO sample share the mid-tick CLK edge.
      if (phase_q == PH_W'(HALF_DIV - 1)) begin
        tck_d = 1'b1;
        if (state_q == S_DR_SHIFT) dout_d[cnt_q[DRI_W-1:0]] = TDO;
      end
      if (phase_q == PH_W'(2 * HALF_DIV - 1)) begin
        // Tick boundary: TCK falls and the next tick's TMS/TDI are launched.
        tck_d   = 1'b0;
        phase_d = '0;
        load    = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
          S_INIT:
            if (cnt_q == CNT_W'(5)) begin state_d = S_IDLE; cnt_d = '0; end
          S_IR_HDR:
            if (cnt_q == CNT_W'(3)) begin state_d = S_IR_SHIFT; cnt_d = '0; end
          S_IR_SHIFT:
            if (cnt_q == CNT_W'(IR_WIDTH - 1)) begin state_d = S_IR_TAIL; cnt_d = '0; end
          S_IR_TAIL:
            if (cnt_q == CNT_W'(1)) begin
              state_d = (len_q != '0) ? S_DR_HDR : S_FIN;
              cnt_d   = '0;
`ifdef JTAG_SKIP_IR_EN
              last_ir_d  = ir_q;
              ir_valid_d = 1'b1;
`endif
            end
          S_DR_HDR:
            if (cnt_q == CNT_W'(2)) begin state_d = S_DR_SHIFT; cnt_d = '0; end
          S_DR_SHIFT:
            if (cnt_q == CNT_W'(len_q) - CNT_W'(1)) begin state_d = S_DR_TAIL; cnt_d = '0; end
          S_DR_TAIL:
            if (cnt_q == CNT_W'(1)) begin state_d = S_FIN; cnt_d = '0; end
          default: ;
        endcase
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end

    dr_last = CNT_W'(len_d) - CNT_W'(1);
    if (load) begin
      tms_d = tms_for(state_d, cnt_d, dr_last);
      case (state_d)
        S_IR_SHIFT: tdi_d = ir_d[cnt_d[IRI_W-1:0]];
        S_DR_SHIFT: tdi_d = dr_d[cnt_d[DRI_W-1:0]];
        default:    tdi_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      phase_q <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      ir_q    <= '0;
      dr_q    <= '0;
      len_q   <= '0;
      dout_q  <= '0;
`ifdef JTAG_SKIP_IR_EN
      last_ir_q  <= '0;
      ir_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      ir_q    <= ir_d;
      dr_q    <= dr_d;
      len_q   <= len_d;
      dout_q  <= dout_d;
`ifdef JTAG_SKIP_IR_EN
      last_ir_q  <= last_ir_d;
      ir_valid_q <= ir_valid_d;
`endif
    end
  end

  assign TCK    = tck_q;
  assign TMS    = tms_q;
  assign TDI    = tdi_q;
  assign BUSY   = !(state_q == S_IDLE || state_q == S_FIN);
  assign DONE   = (state_q == S_FIN);
  assign DR_OUT = dout_q;

endmodule

// File: tb/tb_jtag_tap_master.sv
`timescale 1ns/1ps
module tb_jtag_tap_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  ir_in = '0;
  logic [31:0] dr_in = '0;
  logic [5:0]  dr_len = '0;
  logic        tdo;
  logic        tck, tms, tdi, busy, done;
  logic [31:0] dr_out;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int done_cycles = 0;
  logic tms_log [0:127];
  logic tdi_log [0:127];
  time  tr0, tr1;

  always #5 clk = ~clk;

  // TDO looped back to TDI.
  assign tdo = tdi;

  jtag_tap_master #(.IR_WIDTH(10), .DR_MAX(32), .HALF_DIV(2)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .IR_IN(ir_in), .DR_IN(dr_in),
    .DR_LEN(dr_len), .TDO(tdo), .TCK(tck), .TMS(tms), .TDI(tdi),
    .BUSY(busy), .DONE(done), .DR_OUT(dr_out)
  );

  always @(posedge tck) begin
    if (rises < 128) begin
      tms_log[rises] = tms;
      tdi_log[rises] = tdi;
    end
    if (rises == 0) tr0 = $time;
    if (rises == 1) tr1 = $time;
    rises++;
  end

  always @(posedge clk) if (done) done_cycles++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [9:0] ir, input logic [31:0] dr, input logic [5:0] len);
    @(negedge clk);
    rises = 0;
    done_cycles = 0;
    ir_in = ir; dr_in = dr; dr_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(n < 2000), 64'd1);
    repeat (4) @(negedge clk);
    check({tag, "_done_cycles"}, 64'(done_cycles), 64'd1);
  endtask

  task automatic check_init(input string tag);
    int n = 0;
    logic [5:0] tv;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fall_cycle"}, 64'(n), 64'd24);
    check({tag, "_rises"}, 64'(rises), 64'd6);
    for (int i = 0; i < 6; i++) tv[i] = tms_log[i];
    check({tag, "_tms_seq"}, 64'(tv), 64'b011111);
    check({tag, "_tck_period"}, 64'(tr1 - tr0), 64'd40);
    check({tag, "_tms_idle"}, 64'(tms), 64'd0);
  endtask

  function automatic int ones_count(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (tms_log[i]) c++;
    return c;
  endfunction

  initial begin
    logic [9:0] irv;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dr_out", 64'(dr_out), 64'd0);
    rises = 0;
    rst_n = 1'b1;
    check_init("init");

    // IR 0x3C3 + 12-bit DR, looped back
    launch(10'h3C3, 32'h0000_05A5, 6'd12);
    check("t1_busy_after_start", 64'(busy), 64'd1);
    wait_done("t1");
    check("t1_rises", 64'(rises), 64'd33);
    for (int i = 0; i < 10; i++) irv[i] = tdi_log[4 + i];
    check("t1_ir_tdi", 64'(irv), 64'h3C3);
    check("t1_tms_last_ir", 64'(tms_log[13]), 64'd1);
    check("t1_tms_ir_bit8", 64'(tms_log[12]), 64'd0);
    check("t1_tms_ones", 64'(ones_count(33)), 64'd7);
    check("t1_dr_out", 64'(dr_out), 64'h5A5);
    check("t1_busy_end", 64'(busy), 64'd0);

    // IR scan only
    launch(10'h3C2, 32'hFFFF_FFFF, 6'd0);
    wait_done("t2");
    check("t2_rises", 64'(rises), 64'd16);
    check("t2_tms_ones", 64'(ones_count(16)), 64'd4);
    check("t2_dr_out", 64'(dr_out), 64'd0);

    // DR_LEN beyond DR_MAX is clamped
    launch(10'h155, 32'hDEAD_BEEF, 6'd40);
    wait_done("t3");
    check("t3_rises", 64'(rises), 64'd53);
    check("t3_dr_out", 64'(dr_out), 64'hDEAD_BEEF);
    check("t3_tms_last_dr", 64'(tms_log[50]), 64'd1);

    // START while busy is ignored
    launch(10'h3C3, 32'h0000_05A5, 6'd12);
    n = 0;
    while (rises < 22 && n < 1000) begin @(negedge clk); n++; end
    check("t4_reach_dr", 64'(n < 1000), 64'd1);
    ir_in = 10'h001; dr_in = 32'h0000_0FFF; dr_len = 6'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4");
    repeat (20) @(negedge clk);
    check("t4_rises", 64'(rises), 64'd33);
    check("t4_dr_out", 64'(dr_out), 64'h5A5);
    check("t4_busy_idle", 64'(busy), 64'd0);

    // Reset during DR shift bit 5
    launch(10'h155, 32'h0000_0ABC, 6'd12);
    n = 0;
    while (rises < 25 && n < 1000) begin @(negedge clk); n++; end
    check("t5_reach_bit5", 64'(n < 1000), 64'd1);
    check("t5_partial_dr", 64'(dr_out[4:0]), 64'b11100);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_tck", 64'(tck), 64'd0);
    check("t5_rst_tms", 64'(tms), 64'd1);
    check("t5_rst_dr_out", 64'(dr_out), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd1);
    repeat (2) @(negedge clk);
    rises = 0;
    rst_n = 1'b1;
    check_init("t5_reinit");
    check("t5_no_done", 64'(done_cycles), 64'd0);

`ifdef JTAG_SKIP_IR_EN
    launch(10'h3C3, 32'h0000_05A5, 6'd12);
    wait_done("s1");
    check("s1_rises", 64'(rises), 64'd33);
    launch(10'h3C3, 32'h0000_0A5A, 6'd12);
    wait_done("s2");
    check("s2_rises", 64'(rises), 64'd17);
    check("s2_dr_out", 64'(dr_out), 64'hA5A);
    launch(10'h3C3, 32'h0, 6'd0);
    check("s3_done_next", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    check("s3_no_tck", 64'(rises), 64'd0);
    check("s3_done_cycles", 64'(done_cycles), 64'd1);
    launch(10'h3C2, 32'h0000_05A5, 6'd12);
    wait_done("s4");
    check("s4_rises", 64'(rises), 64'd33);
`else
    launch(10'h3C3, 32'h0000_05A5, 6'd12);
    wait_done("n1");
    check("n1_rises", 64'(rises), 64'd33);
    launch(10'h3C3, 32'h0000_0A5A, 6'd12);
    wait_done("n2");
    check("n2_rises", 64'(rises), 64'd33);
    check("n2_dr_out", 64'(dr_out), 64'hA5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
